hilo_mdu: RTL

Parametrised HI/LO register pair with an attached iterative multiply/divide engine, the next generation of the single HI/LO storage register. It sits beside the ALU in the execute stage and accepts MULT/MULTU/DIV/DIVU (multi-cycle, busy/done handshake) and MTHI/MTLO (single-cycle direct writes). HI and LO are continuously readable for MFHI/MFLO.

---
 rtl/hilo_mdu_pkg.sv | 22 ++
 rtl/hilo_mdu_step.sv | 44 ++++
 rtl/hilo_mdu.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/hilo_mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings, FSM states
// and the divide-by-zero quotient pattern.
package hilo_mdu_pkg;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    // Wide enough for any supported WIDTH; sliced to WIDTH at the use site.
    localparam int                     MDU_MAX_W   = 128;
    localparam logic [MDU_MAX_W-1:0]   MDU_DIV0_LO = '1;

endpackage

// File: rtl/hilo_mdu_step.sv
// One radix-2 iteration: shift-add multiply step (mode_i = 0) or restoring divide
// step (mode_i = 1). The divide path exists only when HILO_MDU_DIV_EN is defined.
module hilo_mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic             mode_i,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic [WIDTH-1:0] m_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH:0] sum;
`ifdef HILO_MDU_DIV_EN
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
`else
    logic           unused_mode;
    assign unused_mode = mode_i;
`endif

    always_comb begin
        // Multiply: add multiplicand on LSB of the multiplier, shift pair right.
        sum  = {1'b0, hi_i} + (lo_i[0] ? {1'b0, m_i} : {(WIDTH+1){1'b0}});
        hi_o = sum[WIDTH:1];
        lo_o = {sum[0], lo_i[WIDTH-1:1]};
`ifdef HILO_MDU_DIV_EN
        shifted = {hi_i, lo_i[WIDTH-1]};
        diff    = shifted - {1'b0, m_i};
        if (mode_i) begin
            // Partial remainder stays below the divisor, so WIDTH bits suffice.
            if (shifted >= {1'b0, m_i}) begin
                hi_o = diff[WIDTH-1:0];
                lo_o = {lo_i[WIDTH-2:0], 1'b1};
            end else begin
                hi_o = shifted[WIDTH-1:0];
                lo_o = {lo_i[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

endmodule

// File: rtl/hilo_mdu.sv
// HI/LO register pair with iterative multiply/divide engine (IDLE -> CALC -> FIX).
// Divide support is compiled in only when HILO_MDU_DIV_EN is defined.
module hilo_mdu
    import hilo_mdu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic               mode_q, mode_d;
    logic               sa_q, sa_d, sb_q, sb_d;
    logic               done_q, done_d;
`ifdef HILO_MDU_DIV_EN
    logic               div0_q, div0_d;
`endif

    logic               is_signed, mult_op, div_op;
    logic [WIDTH-1:0]   a_abs, b_abs, step_hi, step_lo;
    logic [2*WIDTH-1:0] prod;

    hilo_mdu_step #(.WIDTH(WIDTH)) u_step (
        .mode_i (mode_q),
        .hi_i   (acc_hi_q),
        .lo_i   (acc_lo_q),
        .m_i    (m_q),
        .hi_o   (step_hi),
        .lo_o   (step_lo)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        m_d       = m_q;
        mode_d    = mode_q;
        sa_d      = sa_q;
        sb_d      = sb_q;
        done_d    = 1'b0;
`ifdef HILO_MDU_DIV_EN
        div0_d    = div0_q;
        div_op    = (op == OP_DIV) || (op == OP_DIVU);
`else
        div_op    = 1'b0;
`endif
        mult_op   = (op == OP_MULT) || (op == OP_MULTU);
        is_signed = (op == OP_MULT) || (op == OP_DIV);
        a_abs     = (is_signed && a[WIDTH-1]) ? -a : a;
        b_abs     = (is_signed && b[WIDTH-1]) ? -b : b;
        prod      = {acc_hi_q, acc_lo_q};

        case (state_q)
            ST_IDLE: begin
                if (start && !cancel) begin
                    if (op == OP_MTHI) begin
                        hi_d = a;
                    end else if (op == OP_MTLO) begin
                        lo_d = a;
                    end else if (mult_op || div_op) begin
                        acc_hi_d = '0;
                        acc_lo_d = a_abs;
                        m_d      = b_abs;
                        mode_d   = div_op;
                        sa_d     = is_signed && a[WIDTH-1];
                        sb_d     = is_signed && b[WIDTH-1];
`ifdef HILO_MDU_DIV_EN
                        div0_d   = (b == '0);
`endif
                        cnt_d    = '0;
                        state_d  = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_hi_d = step_hi;
                    acc_lo_d = step_lo;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = ST_FIX;
                    end
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                if (!cancel) begin
                    done_d = 1'b1;
`ifdef HILO_MDU_DIV_EN
                    // Quotient sign is the XOR of operand signs; remainder follows the dividend.
                    if (mode_q) begin
                        lo_d = div0_q ? MDU_DIV0_LO[WIDTH-1:0]
                                      : ((sa_q ^ sb_q) ? -acc_lo_q : acc_lo_q);
                        hi_d = sa_q ? -acc_hi_q : acc_hi_q;
                    end else
`endif
                    begin
                        {hi_d, lo_d} = (sa_q ^ sb_q) ? -prod : prod;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            m_q      <= '0;
            mode_q   <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            done_q   <= 1'b0;
`ifdef HILO_MDU_DIV_EN
            div0_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            m_q      <= m_d;
            mode_q   <= mode_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            done_q   <= done_d;
`ifdef HILO_MDU_DIV_EN
            div0_q   <= div0_d;
`endif
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
